// File: rtl/ext_pipe_pkg.sv
// Shared definitions for the immediate/load extension pipeline:
// mode encoding and the two-entry buffer occupancy encoding.
package ext_pipe_pkg;

    typedef enum logic [2:0] {
        EXT_SIGN = 3'd0,
        EXT_ZERO = 3'd1,
        EXT_LUI  = 3'd2,
        EXT_BR   = 3'd3,
        EXT_LB   = 3'd4,
        EXT_LBU  = 3'd5,
        EXT_LH   = 3'd6,
        EXT_LHU  = 3'd7
    } ext_op_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_MAIN  = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/ext_pipe_if.sv
// Request/result handshake bundle for ext_pipe; slave is the pipeline side.
interface ext_pipe_if
    import ext_pipe_pkg::*;
#(
    parameter int IMM_W = 16,
    parameter int W     = 32
);
    logic             in_valid;
    logic             in_ready;
    ext_op_t          in_op;
    logic [IMM_W-1:0] in_imm;
    logic [W-1:0]     in_data;
    logic [1:0]       in_addr_lo;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_ext;
    logic             out_err;

    modport slave (
        input  in_valid, in_op, in_imm, in_data, in_addr_lo, out_ready,
        output in_ready, out_valid, out_ext, out_err
    );

    modport master (
        output in_valid, in_op, in_imm, in_data, in_addr_lo, out_ready,
        input  in_ready, out_valid, out_ext, out_err
    );
endinterface

// File: rtl/ext_pipe_core.sv
// Combinational mode/width computation. Load modes are only built when
// EXT_PIPE_LOAD_EN is defined; otherwise they report an error with zero result.
module ext_core
    import ext_pipe_pkg::*;
#(
    parameter int IMM_W = 16,
    parameter int W     = 32
) (
    input  ext_op_t          op,
    input  logic [IMM_W-1:0] imm,
    input  logic [W-1:0]     data,
    input  logic [1:0]       addr_lo,
    output logic [W-1:0]     ext,
    output logic             err
);
    logic [W-1:0] imm_sext;
    logic         unused_in;

    assign imm_sext  = W'(signed'(imm));
    assign unused_in = ^{data, addr_lo};

`ifdef EXT_PIPE_LOAD_EN
    logic [31:0] word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Byte lanes are defined over a 32-bit word; narrower results see zero upper lanes.
    if (W >= 32) begin : g_word_trunc
        assign word = data[31:0];
    end else begin : g_word_pad
        assign word = {{(32-W){1'b0}}, data};
    end

    assign byte_sel = word[8*addr_lo +: 8];
    assign half_sel = addr_lo[1] ? word[31:16] : word[15:0];
`endif

    always_comb begin
        ext = '0;
        err = 1'b0;
        case (op)
            EXT_SIGN: ext = imm_sext;
            EXT_ZERO: ext = W'(imm);
            EXT_LUI:  ext = W'(imm) << (W - IMM_W);
            EXT_BR:   ext = imm_sext << 2;
`ifdef EXT_PIPE_LOAD_EN
            EXT_LB:   ext = W'(signed'(byte_sel));
            EXT_LBU:  ext = W'(byte_sel);
            EXT_LH: begin
                if (addr_lo[0]) err = 1'b1;
                else            ext = W'(signed'(half_sel));
            end
            EXT_LHU: begin
                if (addr_lo[0]) err = 1'b1;
                else            ext = W'(half_sel);
            end
`else
            default: err = 1'b1;
`endif
        endcase
    end
endmodule

// File: rtl/ext_pipe.sv
// Immediate/load extension with one-cycle latency behind a two-entry skid buffer.
// Optional load modes are enabled by the EXT_PIPE_LOAD_EN macro.
//
// state     | meaning
// BUF_EMPTY | no result held, out_valid=0, in_ready=1
// BUF_MAIN  | result in main register, skid free, in_ready=1
// BUF_FULL  | main and skid both hold results, in_ready=0
module ext_pipe
    import ext_pipe_pkg::*;
#(
    parameter int IMM_W = 16,
    parameter int W     = 32
) (
    input  logic        clk,
    input  logic        reset,
    ext_pipe_if.slave   bus
);
    buf_state_t   state;
    logic [W-1:0] main_ext, skid_ext, core_ext;
    logic         main_err, skid_err, core_err;
    logic         in_ready_r, out_valid_r;
    logic         accept, drain;

    ext_core #(.IMM_W(IMM_W), .W(W)) u_core (
        .op      (bus.in_op),
        .imm     (bus.in_imm),
        .data    (bus.in_data),
        .addr_lo (bus.in_addr_lo),
        .ext     (core_ext),
        .err     (core_err)
    );

    assign accept = bus.in_valid && in_ready_r;
    assign drain  = out_valid_r && bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BUF_EMPTY;
            main_ext    <= '0;
            main_err    <= 1'b0;
            skid_ext    <= '0;
            skid_err    <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                BUF_EMPTY: begin
                    if (accept) begin
                        main_ext    <= core_ext;
                        main_err    <= core_err;
                        out_valid_r <= 1'b1;
                        state       <= BUF_MAIN;
                    end
                end
                BUF_MAIN: begin
                    if (accept && drain) begin
                        main_ext <= core_ext;
                        main_err <= core_err;
                    end else if (accept) begin
                        skid_ext   <= core_ext;
                        skid_err   <= core_err;
                        in_ready_r <= 1'b0;
                        state      <= BUF_FULL;
                    end else if (drain) begin
                        out_valid_r <= 1'b0;
                        state       <= BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    // in_ready is low here, so only a drain can happen.
                    if (drain) begin
                        main_ext   <= skid_ext;
                        main_err   <= skid_err;
                        in_ready_r <= 1'b1;
                        state      <= BUF_MAIN;
                    end
                end
                default: state <= BUF_EMPTY;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_ext   = main_ext;
    assign bus.out_err   = main_err;
endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe: directed cases then randomized traffic
// against a queue-based reference model of the result stream.
module tb_ext_pipe;
    import ext_pipe_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [32:0] q[$];

    always #5 clk = ~clk;

    ext_pipe_if #(.IMM_W(16), .W(32)) bus ();
    ext_pipe #(.IMM_W(16), .W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    // Returns {err, ext} from the arithmetic definition of each mode.
    function automatic logic [32:0] model(input logic [2:0] op, input logic [15:0] imm,
                                          input logic [31:0] data, input logic [1:0] a);
        logic [31:0] s, b, h;
        s = {16'h0, imm};
        if (imm >= 16'h8000) s = s - 32'h0001_0000;
        b = (data >> (8 * 32'(a))) & 32'hFF;
        h = (data >> (16 * 32'(a / 2))) & 32'hFFFF;
        case (op)
            3'd0: return {1'b0, s};
            3'd1: return {1'b0, 16'h0, imm};
            3'd2: return {1'b0, {16'h0, imm} * 32'h0001_0000};
            3'd3: return {1'b0, s * 32'd4};
`ifdef EXT_PIPE_LOAD_EN
            3'd4: return {1'b0, (b >= 32'd128) ? b - 32'd256 : b};
            3'd5: return {1'b0, b};
            3'd6: return (a % 2 == 1) ? {1'b1, 32'h0} : {1'b0, (h >= 32'h8000) ? h - 32'h1_0000 : h};
            3'd7: return (a % 2 == 1) ? {1'b1, 32'h0} : {1'b0, h};
`endif
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, check outputs against the model, advance the clock.
    task automatic cycle(input logic v, input logic [2:0] op, input logic [15:0] imm,
                         input logic [31:0] data, input logic [1:0] a, input logic ordy);
        bit acc, drn;
        bus.in_valid   = v;
        bus.in_op      = ext_op_t'(op);
        bus.in_imm     = imm;
        bus.in_data    = data;
        bus.in_addr_lo = a;
        bus.out_ready  = ordy;
        chk("in_ready", {32'h0, bus.in_ready}, {32'h0, q.size() < 2});
        chk("out_valid", {32'h0, bus.out_valid}, {32'h0, q.size() > 0});
        if (q.size() > 0) chk("result", {bus.out_err, bus.out_ext}, q[0]);
        acc = v && (q.size() < 2);
        drn = ordy && (q.size() > 0);
        if (drn) void'(q.pop_front());
        if (acc) q.push_back(model(op, imm, data, a));
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string tag, input logic [31:0] ext, input logic err);
        chk({tag, "_valid"}, {32'h0, bus.out_valid}, 33'd1);
        chk(tag, {bus.out_err, bus.out_ext}, {err, ext});
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        chk("rst_out_valid", {32'h0, bus.out_valid}, 33'd0);
        chk("rst_in_ready", {32'h0, bus.in_ready}, 33'd1);
        chk("rst_out", {bus.out_err, bus.out_ext}, 33'd0);
    endtask

    initial begin
        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_op      = EXT_SIGN;
        bus.in_imm     = '0;
        bus.in_data    = '0;
        bus.in_addr_lo = '0;
        bus.out_ready  = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Sign extension, one-cycle latency.
        cycle(1, EXT_SIGN, 16'h8001, 0, 0, 1);
        lit("sign_8001", 32'hFFFF8001, 1'b0);
        cycle(0, 0, 0, 0, 0, 1);

        // Back-to-back LUI, BR, ZERO.
        cycle(1, EXT_LUI, 16'h1234, 0, 0, 1);
        lit("lui_1234", 32'h12340000, 1'b0);
        cycle(1, EXT_BR, 16'hFFFF, 0, 0, 1);
        lit("br_ffff", 32'hFFFFFFFC, 1'b0);
        cycle(1, EXT_ZERO, 16'h8000, 0, 0, 1);
        lit("zero_8000", 32'h00008000, 1'b0);
        cycle(0, 0, 0, 0, 0, 1);

        // Loads from one word.
        cycle(1, EXT_LB, 0, 32'h80FF7F01, 2'd1, 1);
`ifdef EXT_PIPE_LOAD_EN
        lit("lb_a1", 32'h0000007F, 1'b0);
        cycle(1, EXT_LBU, 0, 32'h80FF7F01, 2'd1, 1);
        lit("lbu_a1", 32'h0000007F, 1'b0);
        cycle(1, EXT_LH, 0, 32'h80FF7F01, 2'd2, 1);
        lit("lh_a2", 32'hFFFF80FF, 1'b0);
        cycle(1, EXT_LHU, 0, 32'h80FF7F01, 2'd0, 1);
        lit("lhu_a0", 32'h00007F01, 1'b0);
        cycle(1, EXT_LH, 0, 32'h80FF7F01, 2'd3, 1);
        lit("lh_a3_misaligned", 32'h0, 1'b1);
`else
        lit("lb_disabled", 32'h0, 1'b1);
        cycle(1, EXT_LBU, 0, 32'h80FF7F01, 2'd1, 1);
        lit("lbu_disabled", 32'h0, 1'b1);
        cycle(1, EXT_SIGN, 16'h8001, 32'h80FF7F01, 2'd1, 1);
        lit("sign_with_loads_off", 32'hFFFF8001, 1'b0);
`endif
        cycle(0, 0, 0, 0, 0, 1);

        // Backpressure: three offered, two held, output stable, then drain in order.
        cycle(1, EXT_ZERO, 16'h0001, 0, 0, 0);
        cycle(1, EXT_ZERO, 16'h0002, 0, 0, 0);
        chk("bp_in_ready_low", {32'h0, bus.in_ready}, 33'd0);
        cycle(1, EXT_ZERO, 16'h0003, 0, 0, 0);
        lit("bp_hold", 32'h1, 1'b0);
        cycle(1, EXT_ZERO, 16'h0003, 0, 0, 0);
        lit("bp_hold2", 32'h1, 1'b0);
        cycle(0, 0, 0, 0, 0, 1);
        lit("bp_second", 32'h2, 1'b0);
        chk("bp_in_ready_back", {32'h0, bus.in_ready}, 33'd1);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);

        // Reset with both entries full discards everything.
        cycle(1, EXT_ZERO, 16'h00AA, 0, 0, 0);
        cycle(1, EXT_ZERO, 16'h00BB, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 1);

        // Randomized traffic with an occasional reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 16'($urandom),
                  $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
